nmea_stream_parser: RTL
=======================

# nmea_stream_parser

Byte-streaming NMEA-0183 sentence parser. It replaces the fixed 70-character string parser. It sits between the GPS UART receiver and the navigation logic. It consumes one ASCII byte per valid/ready handshake and filters sentences by a parameterised 5-character address such as GPGGA. It splits comma-delimited fields into a parameterised register bank, verifies the `*hh` checksum, and presents each accepted sentence on a valid/ready output port.

## Interface
- `SENTENCE_ID`, `"GPGGA"`: 40-bit ASCII address to accept. First character is in the MSB byte.
- `MAX_FIELDS`, 15: number of data fields captured, counted after the address.
- `FIELD_BYTES`, 12: characters stored per field.
- `TIMEOUT_CYCLES`, 100_000_000: idle cycles allowed between bytes inside a sentence before it is aborted.
- `sclk` input 1: system clock. All logic is on the rising edge.
- `rstn` input 1: asynchronous active-low reset.
- `rx_data` input 8: ASCII byte from the UART.
- `rx_valid` input 1: `rx_data` is valid.
- `rx_ready` output 1: parser accepts `rx_data` this cycle.
- `fields` output MAX_FIELDS\*FIELD_BYTES\*8: field bank.
  - Field i is at `[i*FIELD_BYTES*8 +: FIELD_BYTES*8]`.
  - Character j of a field is at byte j, starting from the LSB.
- `field_len` output MAX_FIELDS\*LW: stored length per field, with LW = $clog2(FIELD_BYTES+1).
- `field_count` output $clog2(MAX_FIELDS+1): number of fields started, saturating at MAX_FIELDS.
- `overflow` output 1: some characters or fields of this sentence were dropped.
- `out_valid` output 1: a complete sentence is presented.
- `out_ready` input 1: consumer accepts the sentence.
- `err_checksum` output 1: one-cycle pulse when the checksum mismatches or is not hex.
- `err_timeout` output 1: one-cycle pulse when a sentence is aborted by the idle timeout.

## Operation
- A byte is accepted when `rx_valid && rx_ready`. `rx_ready` = !`out_valid`.
- States: IDLE, ADDR, SKIP, FIELD, CS_HI, CS_LO, DONE.
  - **IDLE:** ignores every byte except `$`.
  - **On `$` (in any state except DONE):**
    - clear `fields`, `field_len`, `field_count`, `overflow` and the running XOR;
    - reset the address index;
    - go to ADDR.
  - **ADDR:** compares 5 bytes against `SENTENCE_ID`. The 6th byte must be `,`. On a match, set `field_count` = 1 and go to FIELD. Any mismatch goes to SKIP.
  - **SKIP:** waits for `$`. LF goes to IDLE.
  - **FIELD:**
    - `,`: advance the field index. If the index is already MAX_FIELDS-1, set `overflow` and discard all further fields. Otherwise increment `field_count`.
    - `*`: go to CS_HI.
    - CR or LF: go to IDLE silently, because a checksum is mandatory.
    - Any other byte: store it at `field_len[i]` and increment the length. At FIELD_BYTES, drop the byte and set `overflow`.
  - **CS_HI / CS_LO:** read hex digits `0-9`, `A-F` or `a-f` to form the 8-bit received checksum.
  - **DONE:** `out_valid` = 1. Hold until `out_ready`, then go to IDLE.
- Running XOR covers every byte strictly between `$` and `*`, including the address and commas.
- After CS_LO: on a match (or with checksum disabled), go to DONE. On a mismatch or non-hex digit, pulse `err_checksum` and go to IDLE with no `out_valid`.
- Trailing CR/LF after the checksum are consumed in IDLE.
- Timeout:
  - A counter clears on every accepted byte and runs while the state is ADDR, FIELD, CS_HI or CS_LO.
  - At TIMEOUT_CYCLES it pulses `err_timeout` and goes to IDLE.
  - SKIP never times out.
- Outputs `fields`, `field_len`, `field_count` and `overflow` are meaningful only while `out_valid` = 1.

## Timing
- Reset values of all outputs:
  - `rx_ready` = 1.
  - `out_valid`, `err_checksum`, `err_timeout`, `overflow` = 0.
  - `fields`, `field_len`, `field_count` = 0.
  - State = IDLE, XOR = 0, timeout counter = 0.
- Throughput: one byte per cycle with no bubbles, because `rx_ready` stays high until DONE.
- `out_valid` rises in the cycle after the second checksum digit is accepted.
- `err_checksum` pulses in that same cycle, instead of `out_valid`.
- Handshake: `out_valid` falls in the cycle after the cycle with `out_valid && out_ready`, and `rx_ready` rises together with it. A new `$` is accepted in that next cycle at the earliest.
- `err_timeout` pulses for exactly one cycle, TIMEOUT_CYCLES cycles after the last accepted byte.
- If `rstn` is asserted mid-sentence, everything returns to reset values immediately and asynchronously. The partial sentence is discarded.

## Configuration
- `NMEA_CHECKSUM_EN`:
  - **Defined:** the checksum is verified as described in Operation.
  - **Undefined:**
    - CS_HI and CS_LO still consume two bytes, but the value is ignored.
    - Every sentence reaching CS_LO goes to DONE.
    - `err_checksum` is tied to 0.
    - The XOR logic is not synthesised.

## Test plan
- Stream `$GPGGA,1,2*55\r\n` at one byte per cycle:
  - `out_valid` is asserted;
  - `field_count` = 2;
  - field0 = `1`, field1 = `2`, both with `field_len` = 1;
  - `overflow` = 0.
- Stream `$GPGGA,1,2*56\r\n`: `err_checksum` pulses once and no `out_valid`. With `NMEA_CHECKSUM_EN` undefined, `out_valid` is asserted instead.
- Stream `$GPRMC,1*..` followed by the valid GGA sentence: only the GGA sentence is presented, and `field_count` = 2.
- Stream a 14-character field, and 17 fields, with the defaults:
  - `field_len[0]` = 12;
  - `field_count` = 15;
  - `overflow` = 1.
- Hold `out_ready` = 0 for 50 cycles:
  - `rx_ready` = 0 and the outputs are stable;
  - on release, `out_valid` falls one cycle later.
- Cover resync and abort:
  - a `$` mid-field restarts cleanly;
  - stall TIMEOUT_CYCLES inside FIELD: exactly one `err_timeout` pulse;
  - assert `rstn` mid-FIELD: all outputs return to reset values.

Source files
------------

// File: rtl/nmea_stream_parser.sv
`default_nettype none
// ============================================================================
// Module      : nmea_stream_parser
// Description : Byte-streaming NMEA-0183 sentence parser. Filters sentences
//               by a 5-character address, splits comma-delimited fields into
//               a register bank, optionally verifies the *hh checksum and
//               presents each accepted sentence on a valid/ready port.
//               Define NMEA_CHECKSUM_EN to enable checksum verification.
// Revision    : 1.0 - initial release
// ============================================================================
module nmea_stream_parser #(
    parameter logic [39:0] SENTENCE_ID    = "GPGGA",
    parameter int          MAX_FIELDS     = 15,
    parameter int          FIELD_BYTES    = 12,
    parameter int          TIMEOUT_CYCLES = 100_000_000
) (
    input  logic                                         sclk,
    input  logic                                         rstn,
    input  logic [7:0]                                   rx_data,
    input  logic                                         rx_valid,
    output logic                                         rx_ready,
    output logic [MAX_FIELDS*FIELD_BYTES*8-1:0]          fields,
    output logic [MAX_FIELDS*$clog2(FIELD_BYTES+1)-1:0]  field_len,
    output logic [$clog2(MAX_FIELDS+1)-1:0]              field_count,
    output logic                                         overflow,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic                                         err_checksum,
    output logic                                         err_timeout
);

    localparam int c_lw = $clog2(FIELD_BYTES + 1);
    localparam int c_cw = $clog2(MAX_FIELDS + 1);
    localparam int c_iw = (MAX_FIELDS > 1) ? $clog2(MAX_FIELDS) : 1;
    localparam int c_tw = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_addr  = 3'd1;
    localparam logic [2:0] c_st_skip  = 3'd2;
    localparam logic [2:0] c_st_field = 3'd3;
    localparam logic [2:0] c_st_cs_hi = 3'd4;
    localparam logic [2:0] c_st_cs_lo = 3'd5;
    localparam logic [2:0] c_st_done  = 3'd6;

    localparam logic [7:0] c_ch_dollar = 8'h24;
    localparam logic [7:0] c_ch_comma  = 8'h2C;
    localparam logic [7:0] c_ch_star   = 8'h2A;
    localparam logic [7:0] c_ch_cr     = 8'h0D;
    localparam logic [7:0] c_ch_lf     = 8'h0A;

    localparam logic [c_lw-1:0] c_len_full = c_lw'(FIELD_BYTES);
    localparam logic [c_iw-1:0] c_idx_last = c_iw'(MAX_FIELDS - 1);
    localparam logic [c_tw-1:0] c_to_last  = c_tw'(TIMEOUT_CYCLES - 1);

    logic [2:0]                          r_state;
    logic [2:0]                          w_state_next;
    logic [2:0]                          r_addr_idx;
    logic [c_iw-1:0]                     r_field_idx;
    logic [MAX_FIELDS*FIELD_BYTES*8-1:0] r_fields;
    logic [MAX_FIELDS*c_lw-1:0]          r_field_len;
    logic [c_cw-1:0]                     r_field_count;
    logic                                r_overflow;
    logic                                r_discard;
    logic [c_tw-1:0]                     r_timer;
    logic                                r_err_to;

    logic                                w_accept;
    logic                                w_timed;
    logic                                w_to_fire;
    logic [7:0]                          w_id_char;
    logic [c_lw-1:0]                     w_cur_len;
    logic                                w_restart;
    logic                                w_addr_step;
    logic                                w_addr_done;
    logic                                w_store;
    logic                                w_char_drop;
    logic                                w_next_field;
    logic                                w_field_drop;

`ifdef NMEA_CHECKSUM_EN
    logic [7:0]                          r_xor;
    logic [3:0]                          r_cs_hi;
    logic                                r_cs_hi_ok;
    logic                                r_err_cs;
    logic                                w_xor_en;
    logic                                w_cs_hi_load;
    logic                                w_cs_fail;
    logic                                w_hex_ok;
    logic [3:0]                          w_hex_val;
    logic                                w_cs_match;
`endif

    assign w_accept  = rx_valid && (r_state != c_st_done);
    assign w_timed   = (r_state == c_st_addr) || (r_state == c_st_field) ||
                       (r_state == c_st_cs_hi) || (r_state == c_st_cs_lo);
    assign w_to_fire = w_timed && !w_accept && (r_timer == c_to_last);
    assign w_cur_len = r_field_len[int'(r_field_idx)*c_lw +: c_lw];

    // Expected address character for the current position; position 5 is the comma
    always_comb begin
        w_id_char = c_ch_comma;
        case (r_addr_idx)
            3'd0:    w_id_char = SENTENCE_ID[39:32];
            3'd1:    w_id_char = SENTENCE_ID[31:24];
            3'd2:    w_id_char = SENTENCE_ID[23:16];
            3'd3:    w_id_char = SENTENCE_ID[15:8];
            3'd4:    w_id_char = SENTENCE_ID[7:0];
            default: w_id_char = c_ch_comma;
        endcase
    end

`ifdef NMEA_CHECKSUM_EN
    // Decode the incoming byte as a hex digit
    always_comb begin
        w_hex_ok  = 1'b1;
        w_hex_val = 4'h0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            w_hex_val = rx_data[3:0];
        end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                     (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
            w_hex_val = rx_data[3:0] + 4'd9;
        end else begin
            w_hex_ok = 1'b0;
        end
    end

    assign w_cs_match = r_cs_hi_ok && w_hex_ok && ({r_cs_hi, w_hex_val} == r_xor);
`endif

    // Next-state decode and datapath strobes
    always_comb begin
        w_state_next = r_state;
        w_restart    = 1'b0;
        w_addr_step  = 1'b0;
        w_addr_done  = 1'b0;
        w_store      = 1'b0;
        w_char_drop  = 1'b0;
        w_next_field = 1'b0;
        w_field_drop = 1'b0;
`ifdef NMEA_CHECKSUM_EN
        w_xor_en     = 1'b0;
        w_cs_hi_load = 1'b0;
        w_cs_fail    = 1'b0;
`endif
        if (w_to_fire) begin
            w_state_next = c_st_idle;
        end else if (w_accept) begin
            if (rx_data == c_ch_dollar) begin
                // A '$' resynchronises from any state that accepts bytes
                w_restart    = 1'b1;
                w_state_next = c_st_addr;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        w_state_next = c_st_idle;
                    end
                    c_st_addr: begin
`ifdef NMEA_CHECKSUM_EN
                        w_xor_en = 1'b1;
`endif
                        if (rx_data != w_id_char) begin
                            w_state_next = c_st_skip;
                        end else if (r_addr_idx == 3'd5) begin
                            w_addr_done  = 1'b1;
                            w_state_next = c_st_field;
                        end else begin
                            w_addr_step = 1'b1;
                        end
                    end
                    c_st_skip: begin
                        if (rx_data == c_ch_lf) begin
                            w_state_next = c_st_idle;
                        end
                    end
                    c_st_field: begin
                        if (rx_data == c_ch_star) begin
                            w_state_next = c_st_cs_hi;
                        end else if (rx_data == c_ch_cr || rx_data == c_ch_lf) begin
                            // No checksum seen: drop the sentence silently
                            w_state_next = c_st_idle;
                        end else begin
`ifdef NMEA_CHECKSUM_EN
                            w_xor_en = 1'b1;
`endif
                            if (rx_data == c_ch_comma) begin
                                if (!r_discard) begin
                                    if (r_field_idx == c_idx_last) begin
                                        w_field_drop = 1'b1;
                                    end else begin
                                        w_next_field = 1'b1;
                                    end
                                end
                            end else if (!r_discard) begin
                                if (w_cur_len == c_len_full) begin
                                    w_char_drop = 1'b1;
                                end else begin
                                    w_store = 1'b1;
                                end
                            end
                        end
                    end
                    c_st_cs_hi: begin
`ifdef NMEA_CHECKSUM_EN
                        w_cs_hi_load = 1'b1;
`endif
                        w_state_next = c_st_cs_lo;
                    end
                    c_st_cs_lo: begin
`ifdef NMEA_CHECKSUM_EN
                        if (w_cs_match) begin
                            w_state_next = c_st_done;
                        end else begin
                            w_cs_fail    = 1'b1;
                            w_state_next = c_st_idle;
                        end
`else
                        w_state_next = c_st_done;
`endif
                    end
                    default: begin
                        w_state_next = c_st_idle;
                    end
                endcase
            end
        end else if (r_state == c_st_done && out_ready) begin
            w_state_next = c_st_idle;
        end
    end

    // State register
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Inter-byte idle timer; cleared by every accepted byte
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            r_timer  <= '0;
            r_err_to <= 1'b0;
        end else begin
            r_err_to <= w_to_fire;
            if (w_accept || !w_timed || w_to_fire) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + c_tw'(1);
            end
        end
    end

    // Address index, field bank and overflow tracking
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            r_addr_idx    <= '0;
            r_field_idx   <= '0;
            r_fields      <= '0;
            r_field_len   <= '0;
            r_field_count <= '0;
            r_overflow    <= 1'b0;
            r_discard     <= 1'b0;
        end else if (w_restart) begin
            r_addr_idx    <= '0;
            r_field_idx   <= '0;
            r_fields      <= '0;
            r_field_len   <= '0;
            r_field_count <= '0;
            r_overflow    <= 1'b0;
            r_discard     <= 1'b0;
        end else begin
            if (w_addr_step) begin
                r_addr_idx <= r_addr_idx + 3'd1;
            end
            if (w_addr_done) begin
                r_field_count <= c_cw'(1);
            end
            if (w_store) begin
                r_fields[(int'(r_field_idx)*FIELD_BYTES + int'(w_cur_len))*8 +: 8] <= rx_data;
                r_field_len[int'(r_field_idx)*c_lw +: c_lw] <= w_cur_len + c_lw'(1);
            end
            if (w_next_field) begin
                r_field_idx   <= r_field_idx + c_iw'(1);
                r_field_count <= r_field_count + c_cw'(1);
            end
            if (w_char_drop || w_field_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_field_drop) begin
                r_discard <= 1'b1;
            end
        end
    end

`ifdef NMEA_CHECKSUM_EN
    // Running XOR and received checksum capture
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            r_xor      <= '0;
            r_cs_hi    <= '0;
            r_cs_hi_ok <= 1'b0;
            r_err_cs   <= 1'b0;
        end else begin
            r_err_cs <= w_cs_fail;
            if (w_restart) begin
                r_xor <= '0;
            end else if (w_xor_en) begin
                r_xor <= r_xor ^ rx_data;
            end
            if (w_cs_hi_load) begin
                r_cs_hi    <= w_hex_val;
                r_cs_hi_ok <= w_hex_ok;
            end
        end
    end

    assign err_checksum = r_err_cs;
`else
    assign err_checksum = 1'b0;
`endif

    assign rx_ready    = (r_state != c_st_done);
    assign out_valid   = (r_state == c_st_done);
    assign fields      = r_fields;
    assign field_len   = r_field_len;
    assign field_count = r_field_count;
    assign overflow    = r_overflow;
    assign err_timeout = r_err_to;

endmodule
`default_nettype wire
